// File: rtl/store_buffer_if.sv
`default_nettype none
// ============================================================================
// Module  : store_buffer_if
// Brief   : Commit-side store offer, memory write port and status of the
//           store queue.
// Revision: 1.0
// ============================================================================
interface store_buffer_if;
    logic        datafifo_valid_in;
    logic [31:0] datafifo_addr_in;
    logic [31:0] datafifo_val_in;
    logic [1:0]  datafifo_size_in;
    logic        datafifo_full;
    logic        mem_store_valid;
    logic [31:0] mem_store_addr;
    logic [31:0] mem_store_data;
    logic [3:0]  mem_store_strb;
    logic        mem_store_ready;
    logic        store_empty;
    logic        store_error;
    logic [31:0] store_error_addr;

    // Commit stage and memory side, as seen from outside the queue
    modport master (
        output datafifo_valid_in, datafifo_addr_in, datafifo_val_in, datafifo_size_in,
        output mem_store_ready,
        input  datafifo_full, mem_store_valid, mem_store_addr, mem_store_data,
        input  mem_store_strb, store_empty, store_error, store_error_addr
    );

    modport slave (
        input  datafifo_valid_in, datafifo_addr_in, datafifo_val_in, datafifo_size_in,
        input  mem_store_ready,
        output datafifo_full, mem_store_valid, mem_store_addr, mem_store_data,
        output mem_store_strb, store_empty, store_error, store_error_addr
    );
endinterface
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module  : store_buffer
// Brief   : In-order store queue with byte-lane alignment and sticky error
//           reporting for illegal (misaligned / reserved-size) stores.
// Revision: 1.0
// ============================================================================
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  wire logic     clk,
    input  wire logic     reset,
    store_buffer_if.slave bus
);
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    logic [31:0]        r_addr_q [DEPTH];
    logic [31:0]        r_data_q [DEPTH];
    logic [3:0]         r_strb_q [DEPTH];
    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_tail;
    logic [c_cnt_w-1:0] r_count;
    logic               r_error;
    logic [31:0]        r_error_addr;

    logic        w_legal;
    logic [3:0]  w_strb;
    logic [31:0] w_data;
    logic        w_full;
    logic        w_valid;
    logic        w_offer;
    logic        w_push;
    logic        w_pop;

    always_comb begin
        w_legal = 1'b0;
        w_strb  = 4'b0000;
        unique case (bus.datafifo_size_in)
            2'd0: begin
                w_legal = 1'b1;
                w_strb  = 4'b0001 << bus.datafifo_addr_in[1:0];
            end
            2'd1: begin
                w_legal = ~bus.datafifo_addr_in[0];
                w_strb  = 4'b0011 << bus.datafifo_addr_in[1:0];
            end
            2'd2: begin
                w_legal = (bus.datafifo_addr_in[1:0] == 2'b00);
                w_strb  = 4'b1111;
            end
            default: begin
                w_legal = 1'b0;
                w_strb  = 4'b0000;
            end
        endcase
    end

    assign w_data  = bus.datafifo_val_in << {bus.datafifo_addr_in[1:0], 3'b000};
    // Full comes from the registered count only, so a same-cycle pop never frees a slot
    assign w_full  = (r_count == c_depth);
    assign w_valid = (r_count != '0);
    assign w_offer = bus.datafifo_valid_in & ~w_full;
    assign w_push  = w_offer & w_legal;
    assign w_pop   = w_valid & bus.mem_store_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_error      <= 1'b0;
            r_error_addr <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (w_offer && !w_legal) begin
                r_error <= 1'b1;
                if (!r_error) begin
                    r_error_addr <= bus.datafifo_addr_in;
                end
            end
        end
    end

    // Entry storage needs no reset: outputs are masked whenever the queue is empty
    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_addr_q[r_tail] <= {bus.datafifo_addr_in[31:2], 2'b00};
            r_data_q[r_tail] <= w_data;
            r_strb_q[r_tail] <= w_strb;
        end
    end

    assign bus.datafifo_full    = w_full;
    assign bus.mem_store_valid  = w_valid;
    assign bus.mem_store_addr   = w_valid ? r_addr_q[r_head] : 32'h0;
    assign bus.mem_store_data   = w_valid ? r_data_q[r_head] : 32'h0;
    assign bus.mem_store_strb   = w_valid ? r_strb_q[r_head] : 4'h0;
    assign bus.store_empty      = ~w_valid;
    assign bus.store_error      = r_error;
    assign bus.store_error_addr = r_error_addr;
endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module  : tb_store_buffer
// Brief   : Directed self-checking bench for store_buffer.
// Revision: 1.0
// ============================================================================
module tb_store_buffer;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    store_buffer_if bus_if ();

    store_buffer #(.DEPTH(4)) u_dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] addr, input logic [31:0] val, input logic [1:0] size);
        bus_if.datafifo_valid_in = 1'b1;
        bus_if.datafifo_addr_in  = addr;
        bus_if.datafifo_val_in   = val;
        bus_if.datafifo_size_in  = size;
    endtask

    task automatic idle();
        bus_if.datafifo_valid_in = 1'b0;
        bus_if.datafifo_addr_in  = 32'h0;
        bus_if.datafifo_val_in   = 32'h0;
        bus_if.datafifo_size_in  = 2'd0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        idle();
        bus_if.mem_store_ready = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check_eq("rst_valid", 32'(bus_if.mem_store_valid), 32'd0);
        check_eq("rst_empty", 32'(bus_if.store_empty), 32'd1);
        check_eq("rst_full", 32'(bus_if.datafifo_full), 32'd0);
        check_eq("rst_err", 32'(bus_if.store_error), 32'd0);
        check_eq("rst_err_addr", bus_if.store_error_addr, 32'h0);
        check_eq("rst_addr", bus_if.mem_store_addr, 32'h0);
        check_eq("rst_data", bus_if.mem_store_data, 32'h0);
        check_eq("rst_strb", 32'(bus_if.mem_store_strb), 32'h0);

        // Byte store to lane 3
        offer(32'h0000_1003, 32'h0000_00AB, 2'd0);
        #1;
        check_eq("byte_no_comb_path", 32'(bus_if.mem_store_valid), 32'd0);
        step();
        idle();
        check_eq("byte_valid", 32'(bus_if.mem_store_valid), 32'd1);
        check_eq("byte_addr", bus_if.mem_store_addr, 32'h0000_1000);
        check_eq("byte_data", bus_if.mem_store_data, 32'hAB00_0000);
        check_eq("byte_strb", 32'(bus_if.mem_store_strb), 32'h8);
        bus_if.mem_store_ready = 1'b1;
        step();
        bus_if.mem_store_ready = 1'b0;
        check_eq("byte_popped_empty", 32'(bus_if.store_empty), 32'd1);

        // Fill with ready low
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("fill_full_before_%0d", i), 32'(bus_if.datafifo_full), 32'd0);
            offer(32'(4 * i), 32'h1111_1111 * 32'(i + 1), 2'd2);
            step();
        end
        check_eq("fill_full", 32'(bus_if.datafifo_full), 32'd1);
        offer(32'h0000_0010, 32'hDEAD_BEEF, 2'd2);
        step();
        check_eq("fifth_full", 32'(bus_if.datafifo_full), 32'd1);
        check_eq("fifth_head_held", bus_if.mem_store_addr, 32'h0);
        offer(32'h0000_0021, 32'h0, 2'd3);
        step();
        idle();
        check_eq("illegal_while_full_err", 32'(bus_if.store_error), 32'd0);

        // Drain in order
        bus_if.mem_store_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("drain_addr_%0d", i), bus_if.mem_store_addr, 32'(4 * i));
            check_eq($sformatf("drain_data_%0d", i), bus_if.mem_store_data, 32'h1111_1111 * 32'(i + 1));
            check_eq($sformatf("drain_strb_%0d", i), 32'(bus_if.mem_store_strb), 32'hF);
            step();
            if (i == 0) check_eq("full_falls", 32'(bus_if.datafifo_full), 32'd0);
        end
        check_eq("drain_empty", 32'(bus_if.store_empty), 32'd1);
        bus_if.mem_store_ready = 1'b0;

        // Half store, then misaligned word
        offer(32'h0000_2002, 32'h0000_1234, 2'd1);
        step();
        check_eq("half_addr", bus_if.mem_store_addr, 32'h0000_2000);
        check_eq("half_data", bus_if.mem_store_data, 32'h1234_0000);
        check_eq("half_strb", 32'(bus_if.mem_store_strb), 32'hC);
        offer(32'h0000_2002, 32'hCAFE_F00D, 2'd2);
        step();
        idle();
        check_eq("misalign_err", 32'(bus_if.store_error), 32'd1);
        check_eq("misalign_err_addr", bus_if.store_error_addr, 32'h0000_2002);
        bus_if.mem_store_ready = 1'b1;
        step();
        bus_if.mem_store_ready = 1'b0;
        check_eq("misalign_not_queued", 32'(bus_if.store_empty), 32'd1);

        // Reserved size after an earlier error
        offer(32'h0000_3000, 32'h5555_5555, 2'd3);
        step();
        idle();
        check_eq("size3_err", 32'(bus_if.store_error), 32'd1);
        check_eq("size3_err_addr", bus_if.store_error_addr, 32'h0000_2002);
        check_eq("size3_empty", 32'(bus_if.store_empty), 32'd1);

        // Streaming push and pop every cycle
        bus_if.mem_store_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            offer(32'h0000_0100 + 32'(4 * i), 32'h0101_0101 * 32'(i + 1), 2'd2);
            step();
            check_eq($sformatf("stream_valid_%0d", i), 32'(bus_if.mem_store_valid), 32'd1);
            check_eq($sformatf("stream_addr_%0d", i), bus_if.mem_store_addr, 32'h0000_0100 + 32'(4 * i));
            check_eq($sformatf("stream_data_%0d", i), bus_if.mem_store_data, 32'h0101_0101 * 32'(i + 1));
            check_eq($sformatf("stream_full_%0d", i), 32'(bus_if.datafifo_full), 32'd0);
        end
        idle();
        step();
        check_eq("stream_end_empty", 32'(bus_if.store_empty), 32'd1);
        bus_if.mem_store_ready = 1'b0;

        // Reset with entries queued
        for (int i = 0; i < 3; i++) begin
            offer(32'h0000_0040 + 32'(i), 32'(i + 1), 2'd0);
            step();
        end
        idle();
        check_eq("pre_rst_valid", 32'(bus_if.mem_store_valid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("mid_rst_valid", 32'(bus_if.mem_store_valid), 32'd0);
        check_eq("mid_rst_empty", 32'(bus_if.store_empty), 32'd1);
        check_eq("mid_rst_full", 32'(bus_if.datafifo_full), 32'd0);
        check_eq("mid_rst_err", 32'(bus_if.store_error), 32'd0);
        check_eq("mid_rst_err_addr", bus_if.store_error_addr, 32'h0);
        check_eq("mid_rst_data", bus_if.mem_store_data, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
